// File: rtl/wave_pkg.sv
// Shared wavetable constants and fetch FSM state encoding, also used by the interpolator bench.
package wave_pkg;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_FRAC_W = 9;
  localparam int DEF_DATA_W = 8;
  localparam int OVR_W      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR2 = 3'd1,
    DATA1 = 3'd2,
    DATA2 = 3'd3,
    OUT   = 3'd4
  } wave_state_e;

endpackage

// File: rtl/wave_phase_accum.sv
// Phase accumulator: advances by the tuning word on each tick and exposes the pre-tick
// phase split into table index and interpolation fraction.
module wave_phase_accum #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 8,
  parameter int FRAC_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              sync_i,
  input  logic [ACC_W-1:0]  tuning_word_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic [FRAC_W-1:0] frac_o
);

  logic [ACC_W-1:0] acc_q, acc_d, base;

  // A sync forces the phase used this cycle to zero, so a coincident tick fetches phase 0.
  assign base = sync_i ? '0 : acc_q;

  always_comb begin
    acc_d = acc_q;
    if (tick_i)      acc_d = base + tuning_word_i;
    else if (sync_i) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign idx_o  = base[ACC_W-1 -: ADDR_W];
  assign frac_o = base[ACC_W-ADDR_W-1 -: FRAC_W];

endmodule

// File: rtl/wave_sample_fetcher.sv
// Wavetable read side: fetches two adjacent samples per tick and hands (wave1, wave2, fraction)
// to the interpolator. Optional PHASE_SYNC_EN adds a phase_sync input that zeroes the phase.
module wave_sample_fetcher
  import wave_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [ACC_W-1:0]  tuning_word,
`ifdef PHASE_SYNC_EN
  input  logic              phase_sync,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wave1,
  output logic [DATA_W-1:0] wave2,
  output logic [FRAC_W-1:0] fraction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OVR_W-1:0]  overrun_cnt
);

  logic              sync;
  logic [ADDR_W-1:0] idx;
  logic [FRAC_W-1:0] frac;

`ifdef PHASE_SYNC_EN
  assign sync = phase_sync;
`else
  assign sync = 1'b0;
`endif

  wave_phase_accum #(
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W),
    .FRAC_W(FRAC_W)
  ) u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick),
    .sync_i       (sync),
    .tuning_word_i(tuning_word),
    .idx_o        (idx),
    .frac_o       (frac)
  );

  wave_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [FRAC_W-1:0] frac_snap_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] wave1_q, wave2_q;
  logic [FRAC_W-1:0] fraction_q;
  logic              out_valid_q;
  logic [OVR_W-1:0]  ovr_q;
  logic              launch;

  // A tick starts a fetch only when idle or when the current triple is being accepted.
  assign launch = tick && ((state_q == IDLE) || ((state_q == OUT) && out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frac_snap_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      wave1_q     <= '0;
      wave2_q     <= '0;
      fraction_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= '0;
    end else begin
      case (state_q)
        IDLE, OUT: begin
          if (state_q == OUT && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          if (launch) begin
            idx_q       <= idx;
            frac_snap_q <= frac;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= idx;
            state_q     <= ADDR2;
          end
        end
        ADDR2: begin
          mem_addr_q <= idx_q + ADDR_W'(1);
          mem_rd_q   <= 1'b1;
          state_q    <= DATA1;
        end
        DATA1: begin
          wave1_q  <= mem_rdata;
          mem_rd_q <= 1'b0;
          state_q  <= DATA2;
        end
        DATA2: begin
          wave2_q     <= mem_rdata;
          fraction_q  <= frac_snap_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        default: state_q <= IDLE;
      endcase
      if (tick && !launch && ovr_q != {OVR_W{1'b1}})
        ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign wave1       = wave1_q;
  assign wave2       = wave2_q;
  assign fraction    = fraction_q;
  assign out_valid   = out_valid_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_wave_sample_fetcher.sv
// Randomised bench for wave_sample_fetcher against a phase/queue reference model and an identity ROM.
module tb_wave_sample_fetcher;
  import wave_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [23:0] tuning_word = '0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  wave1, wave2;
  logic [8:0]  fraction;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  overrun_cnt;
`ifdef PHASE_SYNC_EN
  logic        phase_sync = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase accumulator, busy flag and queue of expected triples.
  logic [23:0] acc_m = '0;
  bit          busy_m = 0;
  int          ovr_m = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_e = '0;

  always #5 clk = ~clk;

  // Identity ROM, one-cycle registered read.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr;

  wave_sample_fetcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .tuning_word(tuning_word),
`ifdef PHASE_SYNC_EN
    .phase_sync (phase_sync),
`endif
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .wave1      (wave1),
    .wave2      (wave2),
    .fraction   (fraction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {wave1, wave2, fraction} for a fetch at phase ph: idx = top 8 bits, frac = next 9.
  function automatic logic [31:0] triple_at(input logic [23:0] ph);
    int unsigned idx, fr;
    idx = ph / 65536;
    fr  = (ph % 65536) / 128;
    return 32'((idx * 256 + (idx + 1) % 256) * 512 + fr);
  endfunction

  function automatic void model_tick(input logic [23:0] tw, input bit sync);
    logic [23:0] ph;
    ph = sync ? 24'h0 : acc_m;
    if (!busy_m) begin
      exp_q.push_back(triple_at(ph));
      busy_m = 1;
    end else if (ovr_m < 255) begin
      ovr_m++;
    end
    acc_m = ph + tw;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_tick(input logic [23:0] tw, input bit sync);
    model_tick(tw, sync);
    tuning_word = tw;
    tick = 1'b1;
`ifdef PHASE_SYNC_EN
    phase_sync = sync;
`endif
    cyc(1);
    tick = 1'b0;
`ifdef PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 12) begin cyc(1); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_triple(input string tag);
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd0, 32'd1);
    end else begin
      last_e = exp_q.pop_front();
      chk({tag, "_w1"},   32'(wave1),    last_e / (256 * 512));
      chk({tag, "_w2"},   32'(wave2),    (last_e / 512) % 256);
      chk({tag, "_frac"}, 32'(fraction), last_e % 512);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    busy_m = 0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic fetch(input string tag, input logic [23:0] tw, input bit sync);
    drive_tick(tw, sync);
    wait_valid(tag);
    check_triple(tag);
    handshake(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0; busy_m = 0; ovr_m = 0; exp_q.delete();
    cyc(1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(2);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_valid",  32'(out_valid), 0);
    chk("rst_ovr",    32'(overrun_cnt), 0);
    chk("rst_addr",   32'(mem_addr), 0);
    do_reset();

    // Unity step: (0,1,0) then (1,2,0)
    fetch("step1a", 24'h010000, 0);
    fetch("step1b", 24'h010000, 0);

    // Half step: second fetch lands mid-sample
    do_reset();
    fetch("half_a", 24'h008000, 0);
    fetch("half_b", 24'h008000, 0);

    // Index wrap 255 -> 0
    do_reset();
    fetch("wrap_a", 24'hFF8000, 0);
    fetch("wrap_b", 24'h010000, 0);
    fetch("wrap_c", 24'h010000, 0);

    // Backpressure: triple held, ticks counted as overruns
    do_reset();
    drive_tick(24'h010000, 0);
    wait_valid("bp");
    check_triple("bp");
    for (int i = 0; i < 3; i++) begin
      drive_tick(24'h010000, 0);
      cyc(1);
    end
    chk("bp_hold_w1",   32'(wave1),    last_e / (256 * 512));
    chk("bp_hold_w2",   32'(wave2),    (last_e / 512) % 256);
    chk("bp_hold_frac", 32'(fraction), last_e % 512);
    chk("bp_hold_vld",  32'(out_valid), 1);
    chk("bp_ovr3",      32'(overrun_cnt), 32'(ovr_m));
    handshake("bp");
    fetch("bp_after", 24'h010000, 0);

    // Accept and tick in the same cycle relaunches without an overrun
    drive_tick(24'h000300, 0);
    wait_valid("acc_tick");
    check_triple("acc_tick");
    busy_m = 0;
    model_tick(24'h123456, 0);
    tuning_word = 24'h123456;
    out_ready = 1'b1;
    tick = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    tick = 1'b0;
    chk("acc_tick_ovr", 32'(overrun_cnt), 32'(ovr_m));
    wait_valid("acc_tick2");
    check_triple("acc_tick2");
    handshake("acc_tick2");

    // Saturation: 300 back-to-back ticks while stalled
    for (int i = 0; i < 300; i++) drive_tick(24'($urandom), 0);
    chk("ovr_sat", 32'(overrun_cnt), 32'(ovr_m));
    wait_valid("sat");
    check_triple("sat");
    handshake("sat");

    // Random tuning words with idle gaps
    for (int i = 0; i < 20; i++) begin
      fetch("rand", 24'($urandom), 0);
      cyc($urandom_range(0, 3));
    end
    chk("rand_ovr", 32'(overrun_cnt), 32'(ovr_m));

`ifdef PHASE_SYNC_EN
    fetch("sync_pre", 24'h3A5C11, 0);
    fetch("sync_a", 24'h010000, 1);
    fetch("sync_b", 24'h010000, 0);
    phase_sync = 1'b1;
    acc_m = '0;
    cyc(1);
    phase_sync = 1'b0;
    fetch("sync_only", 24'h020000, 0);
`endif

    // Reset mid-fetch clears everything at once and launches nothing afterwards
    drive_tick(24'h010000, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("amid_mem_rd", 32'(mem_rd), 0);
    chk("amid_addr",   32'(mem_addr), 0);
    chk("amid_w1",     32'(wave1), 0);
    chk("amid_w2",     32'(wave2), 0);
    chk("amid_frac",   32'(fraction), 0);
    chk("amid_valid",  32'(out_valid), 0);
    chk("amid_ovr",    32'(overrun_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0; busy_m = 0; ovr_m = 0; exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("post_rst_rd", 32'(mem_rd), 0);
    end
    fetch("post_rst", 24'h010000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
